// File: rtl/aoc5_range_merger_8.sv
// Merges an ascending stream of [lo,hi] ranges delivered 8 at a time into
// maximal disjoint ranges, and reports the total number of covered IDs at stream end.
module aoc5_range_merger_8 #(
  parameter int VAL_W = 64,
  parameter int TOT_W = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic                   last_in,
  input  logic [8*2*VAL_W-1:0]   pairs_in_flat,
  output logic                   stall_out,
  output logic                   range_valid,
  input  logic                   range_ready,
  output logic [VAL_W-1:0]       range_lo,
  output logic [VAL_W-1:0]       range_hi,
  output logic                   range_last,
  output logic                   total_valid,
  output logic [TOT_W-1:0]       total_out,
  output logic [1:0]             dbg_state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [VAL_W:0] ONE_X = 1;

  // Handshake: a range transfers on any cycle with range_valid && range_ready;
  // the range outputs hold while range_valid is high and range_ready is low.

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             buf_last_q, buf_last_d;
  logic [VAL_W-1:0] buf_lo_q [8];
  logic [VAL_W-1:0] buf_hi_q [8];
  logic             load_buf;

  logic             cur_valid_q, cur_valid_d;
  logic [VAL_W-1:0] cur_lo_q, cur_lo_d;
  logic [VAL_W-1:0] cur_hi_q, cur_hi_d;

  logic             out_valid_q, out_valid_d;
  logic [VAL_W-1:0] out_lo_q, out_lo_d;
  logic [VAL_W-1:0] out_hi_q, out_hi_d;
  logic             out_last_q, out_last_d;

  logic [TOT_W-1:0] total_q, total_d;

  logic [VAL_W-1:0] el_lo, el_hi;
  logic [VAL_W:0]   cur_len;
  logic             out_free, consume, emit, emit_last;

  assign el_lo    = buf_lo_q[idx_q];
  assign el_hi    = buf_hi_q[idx_q];
  assign out_free = !out_valid_q || range_ready;
  assign cur_len  = {1'b0, cur_hi_q} - {1'b0, cur_lo_q} + ONE_X;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_last_d  = buf_last_q;
    cur_valid_d = cur_valid_q;
    cur_lo_d    = cur_lo_q;
    cur_hi_d    = cur_hi_q;
    out_valid_d = out_valid_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    out_last_d  = out_last_q;
    total_d     = total_q;
    load_buf    = 1'b0;
    consume     = 1'b0;
    emit        = 1'b0;
    emit_last   = 1'b0;

    if (out_valid_q && range_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          load_buf   = 1'b1;
          idx_d      = 3'd0;
          buf_last_d = last_in;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (el_lo > el_hi) begin
          consume = 1'b1;
        end else if (!cur_valid_q) begin
          cur_valid_d = 1'b1;
          cur_lo_d    = el_lo;
          cur_hi_d    = el_hi;
          consume     = 1'b1;
        end else if ({1'b0, el_lo} <= {1'b0, cur_hi_q} + ONE_X) begin
          if (el_hi > cur_hi_q) cur_hi_d = el_hi;
          consume = 1'b1;
        end else if (out_free) begin
          // Disjoint element: retire the pending range, start a new one.
          emit     = 1'b1;
          cur_lo_d = el_lo;
          cur_hi_d = el_hi;
          consume  = 1'b1;
        end
        if (consume) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = buf_last_q ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cur_valid_q) begin
          if (out_free) begin
            emit        = 1'b1;
            emit_last   = 1'b1;
            cur_valid_d = 1'b0;
          end
        end else if (out_free) begin
          // Output register is empty or its final range transfers now.
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        total_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_lo_d    = cur_lo_q;
      out_hi_d    = cur_hi_q;
      out_last_d  = emit_last;
      total_d     = total_q + TOT_W'(cur_len);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      buf_last_q  <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_lo_q    <= '0;
      cur_hi_q    <= '0;
      out_valid_q <= 1'b0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      out_last_q  <= 1'b0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_last_q  <= buf_last_d;
      cur_valid_q <= cur_valid_d;
      cur_lo_q    <= cur_lo_d;
      cur_hi_q    <= cur_hi_d;
      out_valid_q <= out_valid_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      out_last_q  <= out_last_d;
      total_q     <= total_d;
    end
  end

  // Buffer contents are only meaningful in DRAIN, so they need no reset.
  always_ff @(posedge clock) begin
    if (load_buf) begin
      for (int i = 0; i < 8; i++) begin
        buf_lo_q[i] <= pairs_in_flat[i*2*VAL_W+VAL_W +: VAL_W];
        buf_hi_q[i] <= pairs_in_flat[i*2*VAL_W +: VAL_W];
      end
    end
  end

  assign stall_out   = (state_q != ST_IDLE);
  assign range_valid = out_valid_q;
  assign range_lo    = out_lo_q;
  assign range_hi    = out_hi_q;
  assign range_last  = out_last_q;
  assign total_valid = (state_q == ST_DONE);
  assign total_out   = total_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aoc5_range_merger_8.sv
// Bench for aoc5_range_merger_8: directed and random streams checked against
// a list-merge reference model of the emitted ranges and covered-ID total.
module tb_aoc5_range_merger_8;

  localparam int VW = 64;
  localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            valid_in = 1'b0;
  logic            last_in = 1'b0;
  logic [8*2*VW-1:0] pairs_in_flat = '0;
  logic            stall_out;
  logic            range_valid;
  logic            range_ready = 1'b1;
  logic [VW-1:0]   range_lo, range_hi;
  logic            range_last;
  logic            total_valid;
  logic [63:0]     total_out;
  logic [1:0]      dbg_state_o;

  aoc5_range_merger_8 dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .last_in(last_in),
    .pairs_in_flat(pairs_in_flat), .stall_out(stall_out),
    .range_valid(range_valid), .range_ready(range_ready),
    .range_lo(range_lo), .range_hi(range_hi), .range_last(range_last),
    .total_valid(total_valid), .total_out(total_out), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  logic [63:0]  st_lo[$], st_hi[$];
  logic [128:0] exp_q[$], got_q[$];
  logic [63:0]  got_tot_q[$];
  logic [63:0]  exp_tot;

  initial forever begin
    @(posedge clock); #1;
    if (rdy_mode == 0) range_ready = 1'b1;
    else if (rdy_mode == 2) range_ready = 1'b0;
    else range_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: record every transferred range and every total pulse.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (range_valid && range_ready) got_q.push_back({range_last, range_lo, range_hi});
      if (total_valid) got_tot_q.push_back(total_out);
    end
  end

  // ---------------- reference model ----------------
  task automatic build_model();
    logic [63:0] clo, chi;
    bit have;
    have = 0; clo = 0; chi = 0;
    exp_q.delete();
    exp_tot = 0;
    for (int i = 0; i < st_lo.size(); i++) begin
      if (st_lo[i] > st_hi[i]) continue;
      if (!have) begin
        have = 1; clo = st_lo[i]; chi = st_hi[i];
      end else if ({1'b0, st_lo[i]} <= {1'b0, chi} + 65'd1) begin
        if (st_hi[i] > chi) chi = st_hi[i];
      end else begin
        exp_q.push_back({1'b0, clo, chi});
        exp_tot += chi - clo + 64'd1;
        clo = st_lo[i]; chi = st_hi[i];
      end
    end
    if (have) begin
      exp_q.push_back({1'b1, clo, chi});
      exp_tot += chi - clo + 64'd1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_sb();
    got_q.delete(); got_tot_q.delete(); st_lo.delete(); st_hi.delete();
  endtask

  task automatic add_el(input logic [63:0] lo, input logic [63:0] hi);
    st_lo.push_back(lo); st_hi.push_back(hi);
  endtask

  task automatic gen_random(input int nb);
    logic [63:0] lo;
    lo = 64'($urandom_range(1, 50));
    for (int i = 0; i < nb * 8; i++) begin
      lo += 64'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) lo += 64'($urandom_range(10, 40));
      if ($urandom_range(0, 7) == 0) add_el(lo, lo - 64'd1);
      else add_el(lo, lo + 64'($urandom_range(0, 6)));
    end
  endtask

  task automatic send_block(input int b, input bit last);
    int k;
    @(negedge clock);
    for (k = 0; k < 400 && stall_out; k++) @(negedge clock);
    if (stall_out) begin
      n_cmp++; n_err++;
      $display("FAIL send_block: stall_out stuck at %0b, required 0", stall_out);
    end
    for (int i = 0; i < 8; i++) pairs_in_flat[i*128 +: 128] = {st_lo[b*8+i], st_hi[b*8+i]};
    valid_in = 1'b1;
    last_in = last;
    @(posedge clock); #1;
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic send_stream();
    int nb;
    nb = st_lo.size() / 8;
    for (int b = 0; b < nb; b++) send_block(b, b == nb - 1);
  endtask

  task automatic wait_total(input string name);
    int k;
    for (k = 0; k < 3000 && got_tot_q.size() == 0; k++) @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (got_tot_q.size() == 0) begin
      n_err++;
      $display("FAIL %s timeout: total pulses %0d, required 1", name, got_tot_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({stall_out, range_valid, range_last, total_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset flags: got %b required 0000", {stall_out, range_valid, range_last, total_valid});
    end
    n_cmp++;
    if (range_lo !== 64'd0 || range_hi !== 64'd0 || total_out !== 64'd0) begin
      n_err++;
      $display("FAIL reset values: lo %h hi %h tot %h required zeros", range_lo, range_hi, total_out);
    end
    n_cmp++;
    if (dbg_state_o !== 2'd0) begin
      n_err++;
      $display("FAIL reset state: got %0d required 0", dbg_state_o);
    end
  endtask

  task automatic test_example();
    clear_sb(); rdy_mode = 0;
    add_el(3, 5); add_el(10, 14); add_el(12, 18); add_el(16, 20);
    add_el(30, 30); add_el(31, 31); add_el(40, 39); add_el(50, 50);
    build_model();
    send_stream();
    wait_total("example");
    n_cmp++;
    if (got_q.size() !== 4) begin
      n_err++; $display("FAIL example count: got %0d required 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL example range %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got_tot_q.size() != 1 || got_tot_q[0] !== exp_tot) begin
      n_err++; $display("FAIL example total: got %0d pulses (first %0d) required one of %0d",
                        got_tot_q.size(), (got_tot_q.size() > 0) ? got_tot_q[0] : 64'd0, exp_tot);
    end
  endtask

  task automatic test_cross_block();
    int cnt;
    clear_sb(); rdy_mode = 0;
    add_el(1, 1); add_el(3, 3); add_el(5, 5); add_el(5, 6);
    add_el(6, 6); add_el(6, 5); add_el(6, 6); add_el(8, 9);
    add_el(10, 12); add_el(20, 21); add_el(25, 30); add_el(26, 27);
    add_el(40, 41); add_el(43, 43); add_el(60, 61); add_el(63, 62);
    build_model();
    send_block(0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!stall_out) break;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 8) begin
      n_err++; $display("FAIL cross stall cycles: got %0d required 8", cnt);
    end
    send_block(1, 1'b1);
    wait_total("cross");
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL cross count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL cross range %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got_tot_q.size() != 1 || got_tot_q[0] !== exp_tot) begin
      n_err++; $display("FAIL cross total: got %0d pulses required one of %0d", got_tot_q.size(), exp_tot);
    end
  endtask

  task automatic test_backpressure();
    clear_sb();
    for (int i = 0; i < 8; i++) add_el(64'(2 * i), 64'(2 * i));
    build_model();
    rdy_mode = 2; range_ready = 1'b0;
    send_block(0, 1'b1);
    repeat (3) @(negedge clock);
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (!stall_out || !range_valid || {range_last, range_lo, range_hi} !== exp_q[0]) begin
        n_err++;
        $display("FAIL hold cycle %0d: stall %0b valid %0b range %h required 1 1 %h",
                 k, stall_out, range_valid, {range_last, range_lo, range_hi}, exp_q[0]);
      end
      @(negedge clock);
    end
    rdy_mode = 1;
    wait_total("backpressure");
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL bp count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp range %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got_tot_q.size() != 1 || got_tot_q[0] !== exp_tot) begin
      n_err++; $display("FAIL bp total: got %0d pulses required one of %0d", got_tot_q.size(), exp_tot);
    end
  endtask

  task automatic test_overflow();
    clear_sb(); rdy_mode = 0;
    add_el(5, 7); add_el(MAXV - 64'd1, MAXV); add_el(MAXV, MAXV);
    for (int i = 0; i < 5; i++) add_el(MAXV, MAXV - 64'd1);
    build_model();
    send_stream();
    wait_total("overflow");
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL ovf count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ovf range %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got_tot_q.size() != 1 || got_tot_q[0] !== exp_tot) begin
      n_err++; $display("FAIL ovf total: got %0d pulses required one of %0d", got_tot_q.size(), exp_tot);
    end
  endtask

  task automatic test_reset_mid();
    clear_sb(); rdy_mode = 1;
    for (int i = 0; i < 8; i++) add_el(64'(3 * i + 1), 64'(3 * i + 1));
    send_block(0, 1'b1);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({stall_out, range_valid, range_last, total_valid} !== 4'b0000 ||
        range_lo !== 64'd0 || range_hi !== 64'd0 || total_out !== 64'd0) begin
      n_err++;
      $display("FAIL midreset outputs: flags %b lo %h hi %h tot %h required all zero",
               {stall_out, range_valid, range_last, total_valid}, range_lo, range_hi, total_out);
    end
    reset = 1'b0;
    clear_sb();
    gen_random(2);
    build_model();
    send_stream();
    wait_total("midreset");
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL midreset count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL midreset range %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got_tot_q.size() != 1 || got_tot_q[0] !== exp_tot) begin
      n_err++; $display("FAIL midreset total: got %0d pulses required one of %0d", got_tot_q.size(), exp_tot);
    end
  endtask

  task automatic test_all_invalid();
    clear_sb(); rdy_mode = 0;
    for (int i = 0; i < 8; i++) add_el(64'(10 * i + 5), 64'(10 * i + 2));
    send_stream();
    wait_total("invalid");
    n_cmp++;
    if (got_q.size() !== 0) begin
      n_err++; $display("FAIL invalid count: got %0d ranges required 0", got_q.size());
    end
    n_cmp++;
    if (got_tot_q.size() != 1 || got_tot_q[0] !== 64'd0) begin
      n_err++; $display("FAIL invalid total: got %0d pulses required one of 0", got_tot_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      clear_sb();
      rdy_mode = (s % 2 == 0) ? 1 : 0;
      gen_random(int'($urandom_range(1, 4)));
      build_model();
      send_stream();
      wait_total("random");
      n_cmp++;
      if (got_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL rnd%0d count: got %0d required %0d", s, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rnd%0d range %0d: got %h required %h", s, i, got_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (got_tot_q.size() != 1 || got_tot_q[0] !== exp_tot) begin
        n_err++; $display("FAIL rnd%0d total: got %0d pulses required one of %0d", s, got_tot_q.size(), exp_tot);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_example();
    test_cross_block();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_all_invalid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
